// File: rtl/reg_arb_pkg.sv
// Shared types and default sizes for the register-bank write arbiter.
package reg_arb_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;
  localparam int REG_WIDTH = 8;
  localparam int REG_COUNT = 8;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_picker #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
)(
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);
  logic found;
  int   k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter with locked bursts; issues one registered
// one-hot write per accepted request to the register bank.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int NREGS = REG_COUNT,
  parameter  int WIDTH = REG_WIDTH,
  localparam int AW    = $clog2(NREGS),
  localparam int IW    = $clog2(NREQ)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREGS-1:0]      reg_wen,
  output logic [WIDTH-1:0]      reg_wdata,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic                  addr_err
);
  arb_state_t r_state, w_next;
  logic [IW-1:0]    r_rr_ptr, r_owner, w_idx, w_pick_idx, w_idx_inc;
  logic [NREQ-1:0]  w_pick_gnt, w_ready;
  logic             w_xfer, w_last, w_in_range;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_pick_gnt),
    .gnt_idx (w_pick_idx)
  );

  // Ready never looks at addr/data; the owner keeps ready even with valid low.
  always_comb begin
    w_ready = '0;
    w_idx   = w_pick_idx;
    if (r_state == LOCKED) begin
      w_ready[r_owner] = 1'b1;
      w_idx            = r_owner;
    end else begin
      w_ready = w_pick_gnt;
    end
    if (rst) w_ready = '0;
  end

  assign req_ready  = w_ready;
  assign w_xfer     = |(req_valid & w_ready);
  assign w_last     = req_last[w_idx];
  assign w_addr     = req_addr[int'(w_idx)*AW +: AW];
  assign w_data     = req_data[int'(w_idx)*WIDTH +: WIDTH];
  assign w_in_range = int'(w_addr) < NREGS;
  assign w_idx_inc  = (int'(w_idx) == NREQ-1) ? '0 : w_idx + IW'(1);
  assign busy       = (r_state == LOCKED);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer && !w_last) w_next = LOCKED;
      LOCKED:  if (w_xfer &&  w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state <= w_next;
      if (w_xfer && w_last) r_rr_ptr <= w_idx_inc;
      if (r_state == IDLE && w_xfer && !w_last) r_owner <= w_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_wen   <= '0;
      reg_wdata <= '0;
      grant_id  <= '0;
      addr_err  <= 1'b0;
    end else begin
      reg_wen  <= '0;
      addr_err <= 1'b0;
      if (w_xfer) begin
        reg_wdata <= w_data;
        grant_id  <= w_idx;
        addr_err  <= !w_in_range;
        if (w_in_range) reg_wen <= NREGS'(1) << w_addr;
      end
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: vector table plus reset and address-range sequences.
module tb_reg_write_arbiter;
  logic clk = 1'b1;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  req_valid = '0, req_last = '0, req_ready;
  logic [11:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [7:0]  reg_wen, reg_wdata;
  logic [1:0]  grant_id;
  logic        busy, addr_err;

  logic [3:0]  v2 = '0, l2 = '0, ready2;
  logic [11:0] a2 = '0;
  logic [31:0] d2 = '0;
  logic [5:0]  wen2;
  logic [7:0]  wdata2;
  logic [1:0]  gid2;
  logic        busy2, err2;

  reg_write_arbiter #(.NREQ(4), .NREGS(8), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .reg_wen(reg_wen), .reg_wdata(reg_wdata), .grant_id(grant_id),
    .busy(busy), .addr_err(addr_err));

  reg_write_arbiter #(.NREQ(4), .NREGS(6), .WIDTH(8)) u_dut6 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_last(l2),
    .req_addr(a2), .req_data(d2), .req_ready(ready2),
    .reg_wen(wen2), .reg_wdata(wdata2), .grant_id(gid2),
    .busy(busy2), .addr_err(err2));

  typedef struct {
    logic [3:0]  valid, last;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic        exp_busy;
  } vec_t;

  typedef struct {
    logic [7:0] wen, wdata;
    logic [1:0] gid;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;
  logic [7:0] last_wd = '0;
  logic [1:0] last_gid = '0;

  localparam logic [11:0] A = {3'd7, 3'd6, 3'd5, 3'd4};
  localparam logic [31:0] D = 32'hA3A2A1A0;

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [11:0] a,
                              logic [31:0] d, logic [3:0] r, logic b);
    vec_t t;
    t.valid = v; t.last = l; t.addr = a; t.data = d; t.exp_ready = r; t.exp_busy = b;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("reg_wen", 32'(reg_wen), 32'(e.wen));
      chk("reg_wdata", 32'(reg_wdata), 32'(e.wdata));
      chk("grant_id", 32'(grant_id), 32'(e.gid));
      chk("addr_err", 32'(addr_err), 32'd0);
      last_wd  = e.wdata;
      last_gid = e.gid;
    end else begin
      chk("reg_wen_idle", 32'(reg_wen), 32'd0);
      chk("reg_wdata_hold", 32'(reg_wdata), 32'(last_wd));
      chk("grant_id_hold", 32'(grant_id), 32'(last_gid));
      chk("addr_err_idle", 32'(addr_err), 32'd0);
    end
  endtask

  task automatic cyc(vec_t v);
    exp_t e;
    int idx;
    req_valid = v.valid; req_last = v.last; req_addr = v.addr; req_data = v.data;
    #1;
    chk("req_ready", 32'(req_ready), 32'(v.exp_ready));
    chk("busy", 32'(busy), 32'(v.exp_busy));
    if ((v.exp_ready & v.valid) != 4'd0) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (v.exp_ready[k]) idx = k;
      e.wen   = 8'd1 << v.addr[idx*3 +: 3];
      e.wdata = v.data[idx*8 +: 8];
      e.gid   = 2'(idx);
      q.push_back(e);
    end
    @(posedge clk); #1;
    check_out();
  endtask

  vec_t vecs[20];

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(4'hF, 4'hF, A, D, 4'(1 << (i % 4)), 1'b0);
    vecs[8]  = mk(4'h4, 4'hF, {3'd7, 3'd3, 3'd5, 3'd4}, 32'hA35CA1A0, 4'h4, 1'b0);
    vecs[9]  = mk(4'h0, 4'hF, A, D, 4'h0, 1'b0);
    vecs[10] = mk(4'h1, 4'hF, A, D, 4'h1, 1'b0);
    // requester 1 bursts while requester 0 keeps asking, dropping valid mid-burst
    vecs[11] = mk(4'h3, 4'hD, {3'd7, 3'd6, 3'd0, 3'd4}, 32'hA3A2B0A0, 4'h2, 1'b0);
    vecs[12] = mk(4'h3, 4'hD, {3'd7, 3'd6, 3'd1, 3'd4}, 32'hA3A2B1A0, 4'h2, 1'b1);
    vecs[13] = mk(4'h1, 4'hD, A, D, 4'h2, 1'b1);
    vecs[14] = mk(4'h1, 4'hD, A, D, 4'h2, 1'b1);
    vecs[15] = mk(4'h3, 4'hF, {3'd7, 3'd6, 3'd2, 3'd4}, 32'hA3A2B2A0, 4'h2, 1'b1);
    vecs[16] = mk(4'h1, 4'hF, A, D, 4'h1, 1'b0);
    vecs[17] = mk(4'h0, 4'hF, A, D, 4'h0, 1'b0);
    // requester 3 starts a 3-beat burst that reset will cut short
    vecs[18] = mk(4'h8, 4'h7, {3'd1, 3'd6, 3'd5, 3'd4}, 32'hC1A2A1A0, 4'h8, 1'b0);
    vecs[19] = mk(4'h8, 4'h7, {3'd2, 3'd6, 3'd5, 3'd4}, 32'hC2A2A1A0, 4'h8, 1'b1);

    #15 rst = 1'b1;
    req_valid = 4'hF; req_last = 4'hF; req_addr = A; req_data = D;
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wen", 32'(reg_wen), 32'd0);
    chk("rst_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    #18 rst = 1'b0;

    for (int i = 0; i < 20; i++) cyc(vecs[i]);

    // reset mid-burst: lock drops at once, nothing further issued
    req_last = 4'hF;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wen", 32'(reg_wen), 32'd0);
    chk("mid_rst_wdata", 32'(reg_wdata), 32'd0);
    q.delete();
    @(posedge clk); #1;
    chk("mid_rst_wen2", 32'(reg_wen), 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    #2 rst = 1'b0;
    last_wd = '0; last_gid = '0;
    cyc(mk(4'hF, 4'hF, A, D, 4'h1, 1'b0));
    cyc(mk(4'hF, 4'hF, A, D, 4'h2, 1'b0));
    cyc(mk(4'h0, 4'hF, A, D, 4'h0, 1'b0));

    // out-of-range address on a 6-register bank, then the top valid index
    v2 = 4'h1; l2 = 4'hF; a2 = {3'd0, 3'd0, 3'd0, 3'd7}; d2 = 32'h0000000A;
    #1 chk("r6_ready", 32'(ready2), 32'h1);
    @(posedge clk); #1;
    chk("r6_err", 32'(err2), 32'd1);
    chk("r6_wen_oor", 32'(wen2), 32'd0);
    chk("r6_wdata_oor", 32'(wdata2), 32'h0A);
    a2 = {3'd0, 3'd0, 3'd0, 3'd5}; d2 = 32'h00000033;
    #1 chk("r6_ready2", 32'(ready2), 32'h1);
    @(posedge clk); #1;
    chk("r6_err_clr", 32'(err2), 32'd0);
    chk("r6_wen_top", 32'(wen2), 32'h20);
    chk("r6_wdata", 32'(wdata2), 32'h33);
    v2 = 4'h0;
    @(posedge clk); #1;
    chk("r6_wen_idle", 32'(wen2), 32'd0);
    chk("r6_wdata_hold", 32'(wdata2), 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
